// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: operand/write/load-return bundle for the reg_file_sb
// scoreboarded register file.
//
// Ports (signals of the bundle, direction seen from the register file):
//   r1, r2          in   ADDR_W  source/destination indices
//   rd_en, rd_x_en, rd_y_en, y_is_imm, immediate   operand read request
//   wr_en, result, hi_en, lo_en, swap_en           core writes
//   ld_issue        in   1       memory load issued to r1
//   mem_valid, mem_tag, mem_out  load data return
//   x, y            out  DATA_W  registered operands
//   xy_valid        out  1       x/y were loaded by last cycle's accepted read
//   stall           out  1       current request not accepted
//   pending         out  NREGS   outstanding-load scoreboard
// The slave modport is the register file; master is the controller side.

interface reg_file_sb_if #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4,
   parameter int IMM_W  = 6
) ();
   localparam int ADDR_W = $clog2(NREGS);

   logic [ADDR_W-1:0] r1;
   logic [ADDR_W-1:0] r2;
   logic              rd_en;
   logic              rd_x_en;
   logic              rd_y_en;
   logic              y_is_imm;
   logic [IMM_W-1:0]  immediate;
   logic              wr_en;
   logic [DATA_W-1:0] result;
   logic              hi_en;
   logic              lo_en;
   logic              swap_en;
   logic              ld_issue;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_tag;
   logic [DATA_W-1:0] mem_out;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] y;
   logic              xy_valid;
   logic              stall;
   logic [NREGS-1:0]  pending;

   modport slave (
      input  r1, r2, rd_en, rd_x_en, rd_y_en, y_is_imm, immediate,
             wr_en, result, hi_en, lo_en, swap_en, ld_issue,
             mem_valid, mem_tag, mem_out,
      output x, y, xy_valid, stall, pending
   );

   modport master (
      output r1, r2, rd_en, rd_x_en, rd_y_en, y_is_imm, immediate,
             wr_en, result, hi_en, lo_en, swap_en, ld_issue,
             mem_valid, mem_tag, mem_out,
      input  x, y, xy_valid, stall, pending
   );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with one registered operand-read
// stage (x/y), core writes, half-register immediate loads, a two-register
// swap, and a per-register pending scoreboard for outstanding memory loads.
//
// Ports:
//   clk    in  1   system clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    reg_file_sb_if.slave  request/write/load-return bundle; drives
//          x, y, xy_valid, stall (combinational) and pending.

module reg_file_sb #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4,
   parameter int IMM_W  = 6
) (
   input logic         clk,
   input logic         rst_n,
   reg_file_sb_if.slave bus
);
   localparam int ADDR_W = $clog2(NREGS);
   localparam int HALF_W = DATA_W / 2;

   logic [DATA_W-1:0] mem      [NREGS];
   logic [DATA_W-1:0] mem_next [NREGS];
   logic [NREGS-1:0]  pending_q;
   logic [DATA_W-1:0] x_q;
   logic [DATA_W-1:0] y_q;
   logic              xy_valid_q;

   logic [NREGS-1:0]  ret_mask;
   logic [NREGS-1:0]  eff_pending;
   logic              stall_c;
   logic              accept;
   logic [NREGS-1:0]  pending_next;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W+IMM_W-1:0] imm_wide;
   logic [HALF_W-1:0] imm_half;

   // A load returning this cycle no longer blocks its register.
   assign ret_mask    = bus.mem_valid ? (NREGS'(1) << bus.mem_tag) : '0;
   assign eff_pending = pending_q & ~ret_mask;

   always_comb begin
      stall_c = 1'b0;
      if (bus.rd_en && bus.rd_x_en && eff_pending[bus.r1])
         stall_c = 1'b1;
      if (bus.rd_en && bus.rd_y_en && !bus.y_is_imm && eff_pending[bus.r2])
         stall_c = 1'b1;
      if ((bus.wr_en || bus.hi_en || bus.lo_en || bus.swap_en || bus.ld_issue)
          && eff_pending[bus.r1])
         stall_c = 1'b1;
      if (bus.swap_en && eff_pending[bus.r2])
         stall_c = 1'b1;
   end

   assign accept = !stall_c;

   // Zero-extend, or truncate, the immediate to operand width.
   assign imm_wide = {{DATA_W{1'b0}}, bus.immediate};
   assign imm_ext  = imm_wide[DATA_W-1:0];
   assign imm_half = bus.immediate[HALF_W-1:0];

   // Post-edge register contents. Load returns are applied first so that an
   // accepted core write to the same register overrides them. Every core
   // write targets r1, so an accepted ld_issue drops the whole core write.
   always_comb begin
      for (int i = 0; i < NREGS; i++)
         mem_next[i] = mem[i];
      if (bus.mem_valid)
         mem_next[bus.mem_tag] = bus.mem_out;
      if (accept && !bus.ld_issue) begin
         if (bus.swap_en) begin
            if (bus.r1 != bus.r2) begin
               mem_next[bus.r1] = mem[bus.r2];
               mem_next[bus.r2] = mem[bus.r1];
            end
         end else if (bus.wr_en) begin
            mem_next[bus.r1] = bus.result;
         end else begin
            if (bus.hi_en)
               mem_next[bus.r1][DATA_W-1:HALF_W] = imm_half;
            if (bus.lo_en)
               mem_next[bus.r1][HALF_W-1:0] = imm_half;
         end
      end
   end

   // Set after clear so that a same-cycle return and reissue on one
   // register leaves it pending.
   always_comb begin
      pending_next = pending_q & ~ret_mask;
      if (accept && bus.ld_issue)
         pending_next = pending_next | (NREGS'(1) << bus.r1);
   end

   // Register array, scoreboard and write-first operand stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
         pending_q  <= '0;
         x_q        <= '0;
         y_q        <= '0;
         xy_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= mem_next[i];
         pending_q <= pending_next;
         if (accept && bus.rd_en && bus.rd_x_en)
            x_q <= mem_next[bus.r1];
         if (accept && bus.y_is_imm)
            y_q <= imm_ext;
         else if (accept && bus.rd_en && bus.rd_y_en)
            y_q <= mem_next[bus.r2];
         xy_valid_q <= accept && (bus.rd_en || bus.y_is_imm);
      end
   end

   assign bus.x        = x_q;
   assign bus.y        = y_q;
   assign bus.xy_valid = xy_valid_q;
   assign bus.stall    = stall_c;
   assign bus.pending  = pending_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb with the
// default parameters (DATA_W=8, NREGS=4, IMM_W=6).

module tb_reg_file_sb;
   localparam int DATA_W = 8;
   localparam int NREGS  = 4;
   localparam int IMM_W  = 6;

   logic clk;
   logic rst_n;

   int check_count;
   int error_count;

   reg_file_sb_if #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) bus ();

   reg_file_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Clear every request input.
   task automatic applyStimulus();
      bus.r1 = '0;        bus.r2 = '0;
      bus.rd_en = 0;      bus.rd_x_en = 0;   bus.rd_y_en = 0;
      bus.y_is_imm = 0;   bus.immediate = '0;
      bus.wr_en = 0;      bus.result = '0;
      bus.hi_en = 0;      bus.lo_en = 0;     bus.swap_en = 0;
      bus.ld_issue = 0;
      bus.mem_valid = 0;  bus.mem_tag = '0;  bus.mem_out = '0;
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      applyStimulus();
   endtask

   task automatic write_reg(input logic [1:0] idx, input logic [7:0] val);
      bus.wr_en = 1; bus.r1 = idx; bus.result = val;
      step();
   endtask

   task automatic read_xy(input logic [1:0] a, input logic [1:0] b);
      bus.rd_en = 1; bus.rd_x_en = 1; bus.rd_y_en = 1;
      bus.r1 = a; bus.r2 = b;
      step();
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      rst_n = 0;
      applyStimulus();
      #2;
      checkOutput("reset_x", bus.x, 8'h00);
      checkOutput("reset_y", bus.y, 8'h00);
      checkOutput("reset_xy_valid", bus.xy_valid, 1'b0);
      checkOutput("reset_pending", bus.pending, 4'b0000);
      #10 rst_n = 1;
      step();

      // Basic read after reset
      read_xy(2'd1, 2'd2);
      checkOutput("rd0_x", bus.x, 8'h00);
      checkOutput("rd0_y", bus.y, 8'h00);
      checkOutput("rd0_valid", bus.xy_valid, 1'b1);
      step();
      checkOutput("rd0_valid_drop", bus.xy_valid, 1'b0);

      // Half-register immediate loads, then write-first read
      bus.hi_en = 1; bus.lo_en = 1; bus.r1 = 2'd3; bus.immediate = 6'h25;
      step();
      read_xy(2'd3, 2'd3);
      checkOutput("hilo_x", bus.x, 8'h55);
      bus.wr_en = 1; bus.r1 = 2'd3; bus.result = 8'hA7;
      bus.rd_en = 1; bus.rd_x_en = 1;
      step();
      checkOutput("wr_first_x", bus.x, 8'hA7);
      bus.lo_en = 1; bus.r1 = 2'd3; bus.immediate = 6'h3C;
      step();
      read_xy(2'd3, 2'd0);
      checkOutput("lo_only_x", bus.x, 8'hAC);

      // Swap, read in the same cycle and afterwards
      write_reg(2'd0, 8'h11);
      write_reg(2'd1, 8'h22);
      bus.swap_en = 1;
      read_xy(2'd0, 2'd1);
      checkOutput("swap_wf_x", bus.x, 8'h22);
      checkOutput("swap_wf_y", bus.y, 8'h11);
      read_xy(2'd0, 2'd1);
      checkOutput("swap_x", bus.x, 8'h22);
      checkOutput("swap_y", bus.y, 8'h11);
      write_reg(2'd2, 8'h77);
      bus.swap_en = 1;
      read_xy(2'd2, 2'd2);
      checkOutput("swap_self_x", bus.x, 8'h77);

      // Swap outranks wr_en
      bus.swap_en = 1; bus.wr_en = 1; bus.result = 8'hEE;
      bus.r1 = 2'd0; bus.r2 = 2'd1;
      step();
      read_xy(2'd0, 2'd1);
      checkOutput("prio_x", bus.x, 8'h11);
      checkOutput("prio_y", bus.y, 8'h22);

      // Immediate y without rd_en
      bus.y_is_imm = 1; bus.immediate = 6'h3F;
      step();
      checkOutput("imm_y", bus.y, 8'h3F);
      checkOutput("imm_valid", bus.xy_valid, 1'b1);
      checkOutput("imm_x_hold", bus.x, 8'h11);

      // Load hazard on r2 and its resolution by a return
      bus.ld_issue = 1; bus.r1 = 2'd2;
      step();
      checkOutput("ld_pending", bus.pending, 4'b0100);
      bus.rd_en = 1; bus.rd_x_en = 1; bus.r1 = 2'd2;
      #1 checkOutput("ld_stall", bus.stall, 1'b1);
      step();
      checkOutput("ld_stall_x", bus.x, 8'h11);
      checkOutput("ld_stall_valid", bus.xy_valid, 1'b0);
      bus.rd_en = 1; bus.rd_x_en = 1; bus.r1 = 2'd2;
      bus.mem_valid = 1; bus.mem_tag = 2'd2; bus.mem_out = 8'h3C;
      #1 checkOutput("ret_nostall", bus.stall, 1'b0);
      step();
      checkOutput("ret_x", bus.x, 8'h3C);
      checkOutput("ret_pending", bus.pending, 4'b0000);

      // Core write beats a same-cycle return on the same register
      bus.ld_issue = 1; bus.r1 = 2'd1;
      step();
      checkOutput("ld1_pending", bus.pending, 4'b0010);
      bus.mem_valid = 1; bus.mem_tag = 2'd1; bus.mem_out = 8'h99;
      bus.wr_en = 1; bus.r1 = 2'd1; bus.result = 8'h44;
      #1 checkOutput("race_nostall", bus.stall, 1'b0);
      step();
      checkOutput("race_pending", bus.pending, 4'b0000);
      read_xy(2'd1, 2'd0);
      checkOutput("race_x", bus.x, 8'h44);

      // Build pending=1010 with x=5A, then reset mid-cycle
      bus.wr_en = 1; bus.r1 = 2'd0; bus.result = 8'h5A;
      bus.rd_en = 1; bus.rd_x_en = 1;
      step();
      checkOutput("pre_x", bus.x, 8'h5A);
      bus.ld_issue = 1; bus.r1 = 2'd1;
      step();
      bus.ld_issue = 1; bus.r1 = 2'd3;
      step();
      checkOutput("pre_pending", bus.pending, 4'b1010);
      bus.wr_en = 1; bus.r1 = 2'd3; bus.result = 8'hEE;
      #1 checkOutput("wr_pend_stall", bus.stall, 1'b1);
      #1 rst_n = 0;
      #1;
      checkOutput("rst_pending", bus.pending, 4'b0000);
      checkOutput("rst_x", bus.x, 8'h00);
      checkOutput("rst_valid", bus.xy_valid, 1'b0);
      applyStimulus();
      #4 rst_n = 1;
      step();
      bus.mem_valid = 1; bus.mem_tag = 2'd3; bus.mem_out = 8'h6B;
      step();
      checkOutput("late_ret_pending", bus.pending, 4'b0000);
      read_xy(2'd3, 2'd1);
      checkOutput("late_ret_x", bus.x, 8'h6B);
      checkOutput("post_rst_y", bus.y, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end
endmodule
